// File: rtl/cc_game_controller.sv
// Game sequencer for the 8x8 matrix game: IDLE/PLAY/HIT/GAMEOVER FSM, scroll prescaler,
// lives and score counters. Every output is driven straight from a register.
module cc_game_controller #(
  parameter int TICK_DIV    = 12500000,
  parameter int HIT_TICKS   = 4,
  parameter int LIVES_INIT  = 3,
  parameter int LIVES_WIDTH = 3,
  parameter int SCORE_WIDTH = 8
) (
  input  logic                   CC_GAMECTRL_CLOCK_50,
  input  logic                   CC_GAMECTRL_RESET_InLow,
  input  logic                   CC_GAMECTRL_START_InLow,
  input  logic                   CC_GAMECTRL_COLLISION_InLow,
  output logic                   CC_GAMECTRL_SCROLL_OutHigh,
  output logic                   CC_GAMECTRL_CLEAR_OutHigh,
  output logic                   CC_GAMECTRL_BLINK_OutHigh,
  output logic                   CC_GAMECTRL_GAMEOVER_OutLow,
  output logic [LIVES_WIDTH-1:0] CC_GAMECTRL_LIVES_OutBUS,
  output logic [SCORE_WIDTH-1:0] CC_GAMECTRL_SCORE_OutBUS,
  output logic [1:0]             CC_GAMECTRL_STATE_OutBUS
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int HIT_W   = $clog2(HIT_TICKS + 1);

  localparam logic [PRESC_W-1:0]     TICK_LAST  = PRESC_W'(TICK_DIV - 1);
  localparam logic [HIT_W-1:0]       HIT_LAST   = HIT_W'(HIT_TICKS - 1);
  localparam logic [LIVES_WIDTH-1:0] LIVES_FULL = LIVES_WIDTH'(LIVES_INIT);
  localparam logic [LIVES_WIDTH-1:0] LIVES_ONE  = LIVES_WIDTH'(1);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAY     = 2'd1,
    ST_HIT      = 2'd2,
    ST_GAMEOVER = 2'd3
  } state_t;

  state_t                 r_state;
  logic [PRESC_W-1:0]     r_presc;
  logic [HIT_W-1:0]       r_hit_cnt;
  logic [LIVES_WIDTH-1:0] r_lives;
  logic [SCORE_WIDTH-1:0] r_score;
  logic                   r_scroll;
  logic                   r_clear;
  logic                   r_blink;
  logic                   r_gameover_n;
  // 1 = button was seen pressed on the previous edge. Resetting it to 1 means a
  // button held through reset release needs a release/press before it counts.
  logic                   r_start_held;

  logic w_start_event;
  logic w_tick;
  logic w_collision;

  assign w_start_event = !r_start_held && !CC_GAMECTRL_START_InLow;
  assign w_tick        = ((r_state == ST_PLAY) || (r_state == ST_HIT)) && (r_presc == TICK_LAST);
  // The cycle in which CLEAR is high is a grace cycle: the matrices are being reloaded.
  assign w_collision   = (r_state == ST_PLAY) && !CC_GAMECTRL_COLLISION_InLow && !r_clear;

  always_ff @(posedge CC_GAMECTRL_CLOCK_50 or negedge CC_GAMECTRL_RESET_InLow) begin
    if (!CC_GAMECTRL_RESET_InLow) begin
      r_state      <= ST_IDLE;
      r_presc      <= '0;
      r_hit_cnt    <= '0;
      r_lives      <= LIVES_FULL;
      r_score      <= '0;
      r_scroll     <= 1'b0;
      r_clear      <= 1'b0;
      r_blink      <= 1'b0;
      r_gameover_n <= 1'b1;
      r_start_held <= 1'b1;
    end else begin
      // NOTE: non-blocking everywhere here, so every branch reads the pre-edge values;
      // the two pulses default low and are raised only by the branch that wants them.
      r_start_held <= !CC_GAMECTRL_START_InLow;
      r_scroll     <= 1'b0;
      r_clear      <= 1'b0;

      case (r_state)
        ST_IDLE, ST_GAMEOVER: begin
          if (w_start_event) begin
            r_state      <= ST_PLAY;
            r_clear      <= 1'b1;
            r_lives      <= LIVES_FULL;
            r_score      <= '0;
            r_gameover_n <= 1'b1;
            r_blink      <= 1'b0;
            r_presc      <= '0;
            r_hit_cnt    <= '0;
          end
        end

        ST_PLAY: begin
          if (w_collision) begin
            r_presc   <= '0;
            r_hit_cnt <= '0;
            if (r_lives > LIVES_ONE) begin
              r_state <= ST_HIT;
              r_lives <= r_lives - 1'b1;
              r_blink <= 1'b1;
            end else begin
              r_state      <= ST_GAMEOVER;
              r_lives      <= '0;
              r_blink      <= 1'b0;
              r_gameover_n <= 1'b0;
            end
          end else if (w_tick) begin
            r_presc  <= '0;
            r_scroll <= 1'b1;
            if (r_score != SCORE_MAX) begin
              r_score <= r_score + 1'b1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end

        ST_HIT: begin
          if (w_tick) begin
            r_presc <= '0;
            if (r_hit_cnt == HIT_LAST) begin
              r_state   <= ST_PLAY;
              r_clear   <= 1'b1;
              r_blink   <= 1'b0;
              r_hit_cnt <= '0;
            end else begin
              r_blink   <= !r_blink;
              r_hit_cnt <= r_hit_cnt + 1'b1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign CC_GAMECTRL_SCROLL_OutHigh  = r_scroll;
  assign CC_GAMECTRL_CLEAR_OutHigh   = r_clear;
  assign CC_GAMECTRL_BLINK_OutHigh   = r_blink;
  assign CC_GAMECTRL_GAMEOVER_OutLow = r_gameover_n;
  assign CC_GAMECTRL_LIVES_OutBUS    = r_lives;
  assign CC_GAMECTRL_SCORE_OutBUS    = r_score;
  assign CC_GAMECTRL_STATE_OutBUS    = r_state;

endmodule
